// File: rtl/decade_seq_pkg.sv
// decade_seq_pkg: shared state encoding, command opcodes and digit limit for decade_seq_ctrl
package decade_seq_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HOLD   = 2'd2,
    FINISH = 2'd3
  } state_t;
  localparam logic [1:0] OP_START  = 2'd0;
  localparam logic [1:0] OP_PAUSE  = 2'd1;
  localparam logic [1:0] OP_RESUME = 2'd2;
  localparam logic [1:0] OP_CLEAR  = 2'd3;
  localparam logic [3:0] DIGIT_MAX = 4'd9;
endpackage

// File: rtl/decade_seq_ctrl_prescaler.sv
// tick_prescaler: pulses tick when the count reaches div, i.e. every div+1 enabled clocks; holds while en=0
module tick_prescaler #(
  parameter int DIV_W = 27
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] cnt;
  assign tick = en && cnt == div;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + DIV_W'(1);
endmodule

// File: rtl/decade_seq_ctrl.sv
// decade_seq_ctrl: command-driven 0..9 digit sequencer with prescaler pacing and decade-run limit
// Optional `err` output enabled by defining DECADE_SEQ_ERR_EN.
module decade_seq_ctrl
  import decade_seq_pkg::*;
#(
  parameter int DIV_W = 27,
  parameter int RUN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] div_val,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [RUN_W-1:0] cmd_arg,
  output logic [3:0]       q,
  output logic             busy,
  output logic             wrap,
  output logic             done,
`ifdef DECADE_SEQ_ERR_EN
  output logic             err,
`endif
  output logic [1:0]       state_o
);
  state_t state, state_n;
  logic [DIV_W-1:0] div_l;
  logic [RUN_W-1:0] run_l, dec, dec_n;
  logic [3:0] q_n;
  logic acc, go, clr, tick, last, wrap_n, fin_tick;
  assign acc = cmd_valid && cmd_ready;
  assign go = acc && state == IDLE && cmd_op == OP_START;
  assign clr = acc && cmd_op == OP_CLEAR;
  // the cycle showing the final wrap is still RUN; FINISH follows it, so ticking is suppressed meanwhile
  assign last = wrap && run_l != '0 && dec == run_l;
  assign state_o = state;
  tick_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (state == RUN && !last),
    .clr  (clr || go),
    .div  (div_l),
    .tick (tick)
  );
  always_comb begin
    q_n = q;
    dec_n = dec;
    wrap_n = 1'b0;
    state_n = state;
    if (tick) begin
      wrap_n = q == DIGIT_MAX;
      q_n = wrap_n ? 4'd0 : q + 4'd1;
      dec_n = dec + RUN_W'(wrap_n);
    end
    fin_tick = wrap_n && run_l != '0 && dec_n == run_l;
    case (state)
      IDLE:    state_n = go ? RUN : IDLE;
      RUN:     state_n = last ? FINISH : (acc && cmd_op == OP_PAUSE && !fin_tick) ? HOLD : RUN;
      HOLD:    state_n = (acc && cmd_op == OP_RESUME) ? RUN : HOLD;
      default: state_n = IDLE;
    endcase
    if (clr || go) dec_n = '0;
    if (clr) begin
      state_n = IDLE;
      q_n = 4'd0;
      wrap_n = 1'b0;
    end
  end
`ifdef DECADE_SEQ_ERR_EN
  logic legal, err_n;
  assign legal = cmd_op == OP_CLEAR || (state == IDLE && cmd_op == OP_START) ||
                 (state == RUN && cmd_op == OP_PAUSE) || (state == HOLD && cmd_op == OP_RESUME);
  assign err_n = acc && (!legal || (go && div_val == '0 && cmd_arg == '0));
  always_ff @(posedge clk or posedge reset)
    if (reset) err <= 1'b0;
    else err <= err_n;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      q <= 4'd0;
      dec <= '0;
      div_l <= '0;
      run_l <= '0;
      wrap <= 1'b0;
      done <= 1'b0;
      busy <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      state <= state_n;
      q <= q_n;
      dec <= dec_n;
      wrap <= wrap_n;
      done <= state_n == FINISH;
      busy <= state_n == RUN || state_n == HOLD;
      cmd_ready <= state_n != FINISH;
      if (go) begin
        div_l <= div_val;
        run_l <= cmd_arg;
      end
    end
endmodule

// File: tb/tb_decade_seq_ctrl.sv
// tb_decade_seq_ctrl: directed and randomized checks of decade_seq_ctrl against an elapsed-time reference model
module tb_decade_seq_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic [26:0] div_val = '0;
  logic cmd_valid = 1'b0;
  logic [1:0] cmd_op = '0;
  logic [7:0] cmd_arg = '0;
  logic cmd_ready, busy, wrap, done;
  logic [3:0] q;
  logic [1:0] state_o;
`ifdef DECADE_SEQ_ERR_EN
  logic err;
`endif
  int checks = 0, failures = 0;
  int wraps, dones, first_wrap, gap, n;
  // model: phase 0 idle, 1 running, 2 paused, 3 finishing; digit derived from RUN cycles elapsed since START
  int m_ph, m_dig, m_q0, m_run;
  longint m_t, m_d;
  bit m_wrap, m_done, m_err, m_pend;

  decade_seq_ctrl dut (
    .clk(clk), .reset(reset), .div_val(div_val), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .q(q), .busy(busy), .wrap(wrap), .done(done),
`ifdef DECADE_SEQ_ERR_EN
    .err(err),
`endif
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_ph = 0; m_dig = 0; m_q0 = 0; m_run = 0; m_t = 0; m_d = 1;
    m_wrap = 0; m_done = 0; m_err = 0; m_pend = 0;
  endfunction

  function automatic void model(input bit v, input int op, input int arg, input longint dv);
    bit acc;
    longint k;
    acc = v && m_ph != 3;
    m_wrap = 0;
    m_err = 0;
    if (m_ph == 3) m_ph = 0;
    else if (acc && op == 3) begin
      m_ph = 0; m_dig = 0; m_pend = 0;
    end else if (m_ph == 0) begin
      if (acc && op == 0) begin
        m_ph = 1; m_q0 = m_dig; m_t = 0; m_d = dv + 1; m_run = arg;
        m_err = dv == 0 && arg == 0;
      end else m_err = acc;
    end else if (m_ph == 1) begin
      m_err = acc && op != 1;
      if (m_pend) begin
        m_ph = 3; m_pend = 0;
      end else begin
        m_t++;
        if (m_t % m_d == 0) begin
          k = m_q0 + m_t / m_d;
          m_dig = int'(k % 10);
          m_wrap = m_dig == 0;
          m_pend = m_wrap && m_run != 0 && (k / 10) % 256 == m_run;
        end
        if (acc && op == 1 && !m_pend) m_ph = 2;
      end
    end else begin
      m_err = acc && op != 2;
      if (acc && op == 2) m_ph = 1;
    end
    m_done = m_ph == 3;
  endfunction

  task automatic cycle(input bit v, input int op, input int arg, input int dv);
    cmd_valid = v; cmd_op = op[1:0]; cmd_arg = arg[7:0]; div_val = dv[26:0];
    model(v, op, arg, dv);
    @(posedge clk); #1;
    chk("q", q, m_dig);
    chk("wrap", wrap, m_wrap);
    chk("done", done, m_done);
    chk("busy", busy, m_ph == 1 || m_ph == 2);
    chk("state_o", state_o, m_ph);
    chk("cmd_ready", cmd_ready, m_ph != 3);
`ifdef DECADE_SEQ_ERR_EN
    chk("err", err, m_err);
`endif
    wraps += wrap;
    dones += done;
    n++;
    if (wrap && first_wrap < 0) first_wrap = n;
    else if (wrap) gap = n - first_wrap;
    cmd_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_q", q, 0); chk("rst_state", state_o, 0); chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0); chk("rst_wrap", wrap, 0); chk("rst_done", done, 0);
    // asynchronous reset mid-cycle while running at q=6
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 20 && m_dig != 6; i++) cycle(0, 0, 0, 0);
    chk("pre_rst_q", q, 6);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_q", q, 0); chk("async_rst_state", state_o, 0); chk("async_rst_busy", busy, 0);
    @(posedge clk); #1 reset = 1'b0;
    model_reset();
    // single decade at full speed
    wraps = 0; dones = 0;
    cycle(1, 0, 1, 0);
    for (int i = 0; i < 14; i++) cycle(0, 0, 0, 0);
    chk("run1_wraps", wraps, 1); chk("run1_dones", dones, 1); chk("run1_end_q", q, 0);
    // free-running with div 2 over 100 clocks
    wraps = 0; dones = 0;
    cycle(1, 0, 0, 2);
    for (int i = 0; i < 100; i++) cycle(0, 0, 0, 0);
    chk("free_wraps", wraps, 3); chk("free_dones", dones, 0);
    cycle(1, 3, 0, 0);
    // pause at q=4 with prescaler frozen at 1, resume, q=5 three clocks later
    cycle(1, 0, 0, 3);
    for (int i = 0; i < 40 && m_dig != 4; i++) cycle(0, 0, 0, 0);
    cycle(1, 1, 0, 0);
    repeat (9) cycle(0, 0, 0, 0);
    chk("hold_q", q, 4);
    cycle(1, 2, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("resume_q4", q, 4);
    cycle(0, 0, 0, 0);
    chk("resume_q5", q, 5);
    cycle(1, 3, 0, 0);
    // CLEAR coinciding with the 9->0 tick
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 20 && m_dig != 9; i++) cycle(0, 0, 0, 0);
    cycle(1, 3, 0, 0);
    chk("clr_tick_q", q, 0); chk("clr_tick_wrap", wrap, 0);
    chk("clr_tick_done", done, 0); chk("clr_tick_state", state_o, 0);
    cycle(1, 2, 0, 0);
    chk("idle_resume_state", state_o, 0);
    // two decades: wraps 10 cycles apart, then one done
    wraps = 0; dones = 0; n = 0; first_wrap = -1; gap = 0;
    cycle(1, 0, 2, 0);
    for (int i = 0; i < 25; i++) cycle(0, 0, 0, 0);
    chk("run2_wraps", wraps, 2); chk("run2_gap", gap, 10); chk("run2_dones", dones, 1);
    // randomized command traffic
    cycle(1, 3, 0, 0);
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
